branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the 5-stage MIPS pipeline: predicts next PC in IF from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, then checks the prediction against the branch outcome resolved in ID (the zero/condition flag produced there). It raises a mispredict/redirect to the PC-select logic and trains the table. It sits between the PC register / IF-ID pipeline register and the ID-stage branch test.

## Interface

- ENTRIES, 16: BTB entries, power of two; index = PC[IDX+1:2], IDX = log2(ENTRIES).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- PC_if  input  32  PC of the instruction being fetched.
- PredTaken_if  output  1  fetch-stage prediction: BTB hit and counter MSB set.
- PredTarget_if  output  32  predicted next PC: stored target if PredTaken_if, else PC_if+4.
- Stall  input  1  hazard unit holds IF/ID (load-use stall).
- IF_flush  input  1  IF/ID flush (driven from Mispredict_id at top level).
- Branch_id  input  1  instruction in ID is a conditional branch (beq/bne/bgez/bgtz/bltz/blez).
- Z  input  1  resolved branch condition from ID (1 = taken).
- PC_id  input  32  PC of the instruction in ID.
- BranchAddr_id  input  32  computed branch target in ID.
- Mispredict_id  output  1  prediction carried with the ID instruction was wrong.
- RedirectPC_id  output  32  correct next PC when Mispredict_id = 1.

## Operation

- Entry fields: valid (1), tag = PC[31:IDX+2], target (32), ctr (2).
- Reset: all valid=0, ctr=01, internal prediction register cleared; PredTaken_if=0, PredTarget_if=PC_if+4, Mispredict_id=0, RedirectPC_id = Z?BranchAddr_id:PC_id+4 (combinational, don't-care when Mispredict_id=0).
- Lookup (IF, combinational): hit = valid && tag match at index(PC_if). PredTaken_if = hit && ctr[1].
- Prediction register (IF/ID alongside instruction): captures {PredTaken_if, PredTarget_if} on clock edge when Stall=0. Priority: reset > IF_flush (clears to not-taken, target 0) > Stall (hold) > load.
- Check (ID, combinational), gated by Stall=0:
  - Branch_id=1: mispredict if Z != PredTaken_q, or Z=1 and PredTarget_q != BranchAddr_id.
  - Branch_id=0 and PredTaken_q=1 (alias/stale entry): mispredict, redirect PC_id+4.
  - RedirectPC_id = (Branch_id && Z) ? BranchAddr_id : PC_id+4.
- Update (clock edge, Stall=0 only, index/tag from PC_id):
  - Branch_id, hit: ctr saturating +1 if Z else -1 (00 and 11 saturate); if Z, target <= BranchAddr_id.
  - Branch_id, miss, Z=1: allocate/replace: valid=1, tag, target=BranchAddr_id, ctr=10.
  - Branch_id, miss, Z=0: no change.
  - Branch_id=0, PredTaken_q=1: entry at index(PC_id) valid <= 0.
  - "Hit" in ID is re-evaluated against current table state, not carried from IF.
- Same index read in IF and written in ID in one cycle: IF sees pre-update contents.

## Timing

- Prediction: zero latency, combinational from PC_if.
- Resolution: one cycle after fetch (instruction in ID); mispredict penalty = 1 bubble (IF instruction flushed).
- Table writes take effect on the edge ending the ID cycle; visible to PC_if on the following cycle.
- Stall cycles: no update, Mispredict_id=0 (Z may be unforwarded); evaluation happens on the cycle Stall deasserts.
- reset asserted mid-run: table and prediction register cleared on that edge; any in-flight mispredict is dropped.

## Test plan

- Reset, then PC_if=0x00400000 -> PredTaken_if=0, PredTarget_if=0x00400004; Mispredict_id=0.
- Cold taken beq at 0x00400010, target 0x00400040, Z=1 -> Mispredict_id=1, RedirectPC_id=0x00400040; next fetch of 0x00400010 -> PredTaken_if=1, PredTarget_if=0x00400040.
- Same branch taken 3 more times (ctr 11), then Z=0 -> Mispredict_id=1, RedirectPC_id=0x00400014; next fetch still predicts taken (ctr 10); second Z=0 -> ctr 01, predicts not-taken.
- Branch in ID with Stall=1 for 2 cycles, Z toggling -> Mispredict_id=0, ctr unchanged; Stall=0, Z=1 -> single evaluation and single update.
- Alias: entry trained at 0x00400010, fetch non-branch at 0x00400010+4*ENTRIES with matching tag forced via stale entry -> predicted taken, Branch_id=0 in ID -> Mispredict_id=1, RedirectPC_id=PC_id+4, entry invalidated; refetch predicts not-taken.
- Assert reset for one cycle while a trained entry exists and a taken prediction is in ID -> Mispredict_id=0 next cycle, PredTaken_if=0 for the previously trained PC.

Source files
------------

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the 5-stage MIPS pipeline. A direct-mapped
// branch target buffer (BTB) with 2-bit saturating counters predicts the
// next PC during fetch. The prediction travels with the instruction into ID,
// where it is checked against the resolved branch condition. A wrong guess
// raises Mispredict_id with the correct next PC, and the table is trained.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   PC_if          PC of the instruction being fetched
//   PredTaken_if   fetch prediction: BTB hit and counter MSB set
//   PredTarget_if  predicted next PC (stored target or PC_if+4)
//   Stall          hazard unit holds IF/ID (no evaluation, no update)
//   IF_flush       IF/ID flush; clears the carried prediction
//   Branch_id      instruction in ID is a conditional branch
//   Z              resolved branch condition in ID (1 = taken)
//   PC_id          PC of the instruction in ID
//   BranchAddr_id  computed branch target in ID
//   Mispredict_id  prediction carried with the ID instruction was wrong
//   RedirectPC_id  correct next PC when Mispredict_id = 1
// ---------------------------------------------------------------------------
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_if,
   output logic        PredTaken_if,
   output logic [31:0] PredTarget_if,
   input  logic        Stall,
   input  logic        IF_flush,
   input  logic        Branch_id,
   input  logic        Z,
   input  logic [31:0] PC_id,
   input  logic [31:0] BranchAddr_id,
   output logic        Mispredict_id,
   output logic [31:0] RedirectPC_id
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX;

   // BTB storage
   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   // Saturating 2-bit counter step: 11 stays on taken, 00 stays on not-taken.
   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
      logic [1:0] r;
      r = c;
      if (up && c != 2'b11)
         r = c + 2'd1;
      else if (!up && c != 2'b00)
         r = c - 2'd1;
      return r;
   endfunction

   // ---- IF stage (p0): combinational lookup --------------------------------
   logic [IDX-1:0]   idx_p0;
   logic [TAG_W-1:0] tag_p0;
   logic             hit_p0;
   logic [31:0]      seq_pc_p0;

   assign idx_p0    = PC_if[IDX+1:2];
   assign tag_p0    = PC_if[31:IDX+2];
   assign hit_p0    = valid_q[idx_p0] && (tag_q[idx_p0] == tag_p0);
   assign seq_pc_p0 = PC_if + 32'd4;

   // Output is forced low while reset is held so PC-select never follows a
   // stale entry during the reset cycle.
   assign PredTaken_if  = hit_p0 && ctr_q[idx_p0][1] && !reset;
   assign PredTarget_if = PredTaken_if ? target_q[idx_p0] : seq_pc_p0;

   // ---- IF/ID boundary (p1): prediction carried with the instruction --------
   logic        pred_taken_p1;
   logic [31:0] pred_target_p1;

   always_ff @(posedge clk) begin
      if (reset || IF_flush) begin
         pred_taken_p1  <= 1'b0;
         pred_target_p1 <= 32'd0;
      end else if (!Stall) begin
         pred_taken_p1  <= PredTaken_if;
         pred_target_p1 <= PredTarget_if;
      end
   end

   // ---- ID stage (p1): check against resolved outcome ----------------------
   logic [IDX-1:0]   idx_p1;
   logic [TAG_W-1:0] tag_p1;
   logic             hit_p1;
   logic [31:0]      seq_pc_p1;
   logic             wrong_p1;

   assign idx_p1    = PC_id[IDX+1:2];
   assign tag_p1    = PC_id[31:IDX+2];
   // Hit is re-evaluated against the current table, not carried from IF.
   assign hit_p1    = valid_q[idx_p1] && (tag_q[idx_p1] == tag_p1);
   assign seq_pc_p1 = PC_id + 32'd4;

   always_comb begin
      wrong_p1 = 1'b0;
      if (Branch_id)
         wrong_p1 = (Z != pred_taken_p1) ||
                    (Z && (pred_target_p1 != BranchAddr_id));
      else
         // Non-branch predicted taken: aliased or stale BTB entry.
         wrong_p1 = pred_taken_p1;
   end

   // While stalled Z may not be forwarded yet, so no verdict is given.
   assign Mispredict_id = wrong_p1 && !Stall && !reset;
   assign RedirectPC_id = (Branch_id && Z) ? BranchAddr_id : seq_pc_p1;

   // ---- ID/EX boundary: table training, written on the edge ending ID ------
   // IF reads in the same cycle see the pre-update contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (!Stall) begin
         if (Branch_id) begin
            if (hit_p1) begin
               ctr_q[idx_p1] <= ctr_next(ctr_q[idx_p1], Z);
            end else if (Z) begin
               valid_q[idx_p1] <= 1'b1;
               ctr_q[idx_p1]   <= 2'b10;
            end
         end else if (pred_taken_p1) begin
            valid_q[idx_p1] <= 1'b0;
         end
      end
   end

   // Tag and target carry no reset; they are meaningless while valid is low.
   // On a hit the tag already matches, so rewriting it is harmless.
   always_ff @(posedge clk) begin
      if (!Stall && Branch_id && Z) begin
         tag_q[idx_p1]    <= tag_p1;
         target_q[idx_p1] <= BranchAddr_id;
      end
   end

   // Byte-offset bits are never part of index or tag.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PC_if[1:0], PC_id[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor (ENTRIES = 16). Inputs are driven just
// after the falling edge; outputs are sampled 1 ns later, well before the
// next rising edge. Expected values are hand-derived from the BTB behaviour.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

   localparam logic [31:0] BPC = 32'h0040_0010;  // branch PC, index 4
   localparam logic [31:0] TGT = 32'h0040_0040;  // branch target
   localparam logic [31:0] OTH = 32'h0040_0100;  // filler fetch, index 0
   localparam logic [31:0] ALI = 32'h0040_0050;  // BPC + 4*ENTRIES, same index

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC_if;
   logic        PredTaken_if;
   logic [31:0] PredTarget_if;
   logic        Stall;
   logic        IF_flush;
   logic        Branch_id;
   logic        Z;
   logic [31:0] PC_id;
   logic [31:0] BranchAddr_id;
   logic        Mispredict_id;
   logic [31:0] RedirectPC_id;

   int n_checks = 0;
   int n_fail   = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .PC_if         (PC_if),
      .PredTaken_if  (PredTaken_if),
      .PredTarget_if (PredTarget_if),
      .Stall         (Stall),
      .IF_flush      (IF_flush),
      .Branch_id     (Branch_id),
      .Z             (Z),
      .PC_id         (PC_id),
      .BranchAddr_id (BranchAddr_id),
      .Mispredict_id (Mispredict_id),
      .RedirectPC_id (RedirectPC_id)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One cycle of stimulus; outputs are settled when this returns.
   task automatic drive(input logic rst, input logic [31:0] pc_f,
                        input logic st, input logic fl, input logic br,
                        input logic z_v, input logic [31:0] pc_d,
                        input logic [31:0] baddr);
      @(negedge clk);
      reset         = rst;
      PC_if         = pc_f;
      Stall         = st;
      IF_flush      = fl;
      Branch_id     = br;
      Z             = z_v;
      PC_id         = pc_d;
      BranchAddr_id = baddr;
      #1;
   endtask

   // Fetch BPC, then resolve it in ID with outcome z_v.
   task automatic pair(input string nm, input logic z_v, input logic exp_pred,
                       input logic exp_mis, input logic [31:0] exp_redir);
      drive(1'b0, BPC, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val({nm, " pred"}, {31'd0, PredTaken_if}, {31'd0, exp_pred});
      check_val({nm, " ptgt"}, PredTarget_if, exp_pred ? TGT : BPC + 32'd4);
      drive(1'b0, OTH, 1'b0, 1'b0, 1'b1, z_v, BPC, TGT);
      check_val({nm, " mis"}, {31'd0, Mispredict_id}, {31'd0, exp_mis});
      if (exp_mis)
         check_val({nm, " redir"}, RedirectPC_id, exp_redir);
   endtask

   initial begin
      // Reset and idle fetch
      drive(1'b1, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("rst_pred_during", {31'd0, PredTaken_if}, 32'd0);
      drive(1'b1, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b0, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("rst_pred", {31'd0, PredTaken_if}, 32'd0);
      check_val("rst_ptgt", PredTarget_if, 32'h0040_0004);
      check_val("rst_mis", {31'd0, Mispredict_id}, 32'd0);

      // Cold taken branch allocates (ctr 10), then trains to 11
      pair("cold",   1'b1, 1'b0, 1'b1, TGT);          // -> 10
      pair("tk1",    1'b1, 1'b1, 1'b0, TGT);          // -> 11
      pair("tk2",    1'b1, 1'b1, 1'b0, TGT);          // -> 11
      pair("tk3",    1'b1, 1'b1, 1'b0, TGT);          // -> 11
      pair("nt1",    1'b0, 1'b1, 1'b1, BPC + 32'd4);  // -> 10
      pair("nt2",    1'b0, 1'b1, 1'b1, BPC + 32'd4);  // -> 01
      pair("retk",   1'b1, 1'b0, 1'b1, TGT);          // -> 10

      // Stall: two held cycles with Z=0 must neither flag nor train
      drive(1'b0, BPC, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("stall_fetch", {31'd0, PredTaken_if}, 32'd1);
      drive(1'b0, OTH, 1'b1, 1'b0, 1'b1, 1'b0, BPC, TGT);
      check_val("stall_mis1", {31'd0, Mispredict_id}, 32'd0);
      drive(1'b0, OTH, 1'b1, 1'b0, 1'b1, 1'b0, BPC, TGT);
      check_val("stall_mis2", {31'd0, Mispredict_id}, 32'd0);
      drive(1'b0, OTH, 1'b0, 1'b0, 1'b1, 1'b1, BPC, TGT);
      check_val("stall_rel", {31'd0, Mispredict_id}, 32'd0);  // -> 11

      // Walk counter down, through saturation at 00, and back up
      pair("dn1",    1'b0, 1'b1, 1'b1, BPC + 32'd4);  // -> 10
      pair("dn2",    1'b0, 1'b1, 1'b1, BPC + 32'd4);  // -> 01
      pair("dn3",    1'b0, 1'b0, 1'b0, 32'd0);        // -> 00
      pair("sat0",   1'b0, 1'b0, 1'b0, 32'd0);        // stays 00
      pair("up1",    1'b1, 1'b0, 1'b1, TGT);          // -> 01
      pair("up2",    1'b1, 1'b0, 1'b1, TGT);          // -> 10
      pair("up3",    1'b1, 1'b1, 1'b0, TGT);          // -> 11

      // IF_flush clears the carried prediction
      drive(1'b0, BPC, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("flush_fetch", {31'd0, PredTaken_if}, 32'd1);
      drive(1'b0, OTH, 1'b0, 1'b0, 1'b0, 1'b0, BPC, 32'd0);
      check_val("flush_mis", {31'd0, Mispredict_id}, 32'd0);

      // Same index, different tag: miss
      drive(1'b0, ALI, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("alias_pred", {31'd0, PredTaken_if}, 32'd0);
      check_val("alias_ptgt", PredTarget_if, ALI + 32'd4);

      // Stale entry: non-branch predicted taken -> redirect and invalidate
      drive(1'b0, BPC, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("stale_pred", {31'd0, PredTaken_if}, 32'd1);
      drive(1'b0, OTH, 1'b0, 1'b0, 1'b0, 1'b0, BPC, 32'd0);
      check_val("stale_mis", {31'd0, Mispredict_id}, 32'd1);
      check_val("stale_redir", RedirectPC_id, 32'h0040_0014);
      drive(1'b0, BPC, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("stale_inval", {31'd0, PredTaken_if}, 32'd0);
      check_val("stale_ptgt", PredTarget_if, BPC + 32'd4);

      // Mid-run reset with a taken prediction in ID
      pair("retrain", 1'b1, 1'b0, 1'b1, TGT);         // -> 10
      drive(1'b0, BPC, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("mr_fetch", {31'd0, PredTaken_if}, 32'd1);
      drive(1'b1, OTH, 1'b0, 1'b0, 1'b1, 1'b0, BPC, TGT);
      check_val("mr_mis_rst", {31'd0, Mispredict_id}, 32'd0);
      drive(1'b0, BPC, 1'b0, 1'b0, 1'b1, 1'b0, BPC, TGT);
      check_val("mr_mis_after", {31'd0, Mispredict_id}, 32'd0);
      check_val("mr_pred_after", {31'd0, PredTaken_if}, 32'd0);
      check_val("mr_ptgt_after", PredTarget_if, BPC + 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
